mem_responder: RTL and testbench

//  Memory-side responder for the cache's backing-memory request/response interface.
//  - Accepts read and write requests from one initiator: the cache's refill/writeback port.
//  - Holds a synthesizable MEM_DATA_BITS-wide backing array.
//  - Returns one read beat per read request after a fixed, programmable latency.
//  - Used as the main-memory model under the cache in block and full-system sims.

---
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-initiator backing-memory model: one outstanding read or write, fixed read latency,
// byte-masked writes, one-cycle read response with no backpressure.
module mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid_i,
  output logic                   mem_req_ready_o,
  input  logic [ADDR_BITS-1:0]   mem_req_addr_i,
  input  logic                   mem_req_rw_i,
  input  logic                   mem_req_data_valid_i,
  output logic                   mem_req_data_ready_o,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits_i,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask_i,
  output logic                   mem_resp_valid_o,
  output logic [DATA_BITS-1:0]   mem_resp_data_o
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CW     = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic                  wr_en;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_req_addr_i[ADDR_BITS-1:DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_valid_i) begin
          addr_d = mem_req_addr_i[DEPTH_LOG2-1:0];
          if (mem_req_rw_i) begin
            state_d = S_WDATA;
          end else if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WDATA: if (mem_req_data_valid_i) state_d = S_IDLE;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_ready_o      = (state_q == S_IDLE)  && !reset;
    mem_req_data_ready_o = (state_q == S_WDATA) && !reset;
    mem_resp_valid_o     = (state_q == S_RESP)  && !reset;
    wr_en                = mem_req_data_ready_o && mem_req_data_valid_i;
    mem_resp_data_o      = mem_resp_valid_o ? mem_q[addr_q] : '0;
  end

  // Array is never reset; a write is suppressed in a reset cycle so nothing lands partially.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_req_data_mask_i[b]) mem_q[addr_q][8*b +: 8] <= mem_req_data_bits_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=4: reset, writes, masked writes, refill burst,
// aliasing/ignored data beats and reset during a pending read.
module tb_mem_responder;
  localparam int AB = 28, DB = 128, DL = 12, LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_rw, dvalid, dready, resp_valid;
  logic [AB-1:0] req_addr;
  logic [DB-1:0] dbits, resp_data;
  logic [DB/8-1:0] dmask;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid_i(req_valid), .mem_req_ready_o(req_ready),
    .mem_req_addr_i(req_addr), .mem_req_rw_i(req_rw),
    .mem_req_data_valid_i(dvalid), .mem_req_data_ready_o(dready),
    .mem_req_data_bits_i(dbits), .mem_req_data_mask_i(dmask),
    .mem_resp_valid_o(resp_valid), .mem_resp_data_o(resp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
    dvalid = 1'b0; dbits = '0; dmask = '0;
  endtask

  task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [DB/8-1:0] m);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a;
    dvalid = 1'b1; dbits = d; dmask = m;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready addr=%h got=%b exp=1", a, req_ready); end
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (dready !== 1'b1) begin n_err++; $display("FAIL wr_dready addr=%h got=%b exp=1", a, dready); end
    tick();
    idle_inputs();
  endtask

  // Issues a read in the current cycle; returns data and cycles from acceptance to resp_valid.
  task automatic do_read(input logic [AB-1:0] a, output logic [DB-1:0] d, output int lat);
    d = '0; lat = -1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready addr=%h got=%b exp=1", a, req_ready); end
    tick();
    idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid === 1'b1) begin lat = k; d = resp_data; break; end
      n_cmp++;
      if (req_ready !== 1'b0 || resp_data !== '0) begin
        n_err++; $display("FAIL rd_wait addr=%h k=%0d ready=%b data=%h exp ready=0 data=0", a, k, req_ready, resp_data);
      end
      tick();
    end
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_data !== '0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_after addr=%h valid=%b data=%h ready=%b exp 0/0/1", a, resp_valid, resp_data, req_ready);
    end
  endtask

  task automatic check_read(input string nm, input logic [AB-1:0] a, input logic [DB-1:0] exp);
    logic [DB-1:0] d;
    int lat;
    do_read(a, d, lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL %s_lat got=%0d exp=%0d", nm, lat, LAT); end
    n_cmp++;
    if (d !== exp) begin n_err++; $display("FAIL %s_data got=%h exp=%h", nm, d, exp); end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || dready !== 1'b0 || resp_data !== '0) begin
        n_err++; $display("FAIL reset_hold cyc=%0d ready=%b rv=%b dr=%b data=%h exp all 0", i, req_ready, resp_valid, dready, resp_data);
      end
    end
    req_valid = 1'b0;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_exit ready=%b rv=%b exp 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write_read();
    do_write(28'h5, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
    check_read("wr_rd", 28'h5, 128'h0123456789ABCDEF0123456789ABCDEF);
  endtask

  task automatic test_masked_write();
    do_write(28'h9, {16{8'hAA}}, 16'hFFFF);
    do_write(28'h9, {16{8'h55}}, 16'h000F);
    check_read("mask", 28'h9, {{12{8'hAA}}, {4{8'h55}}});
    do_write(28'h9, {16{8'h11}}, 16'h0000);
    check_read("mask0", 28'h9, {{12{8'hAA}}, {4{8'h55}}});
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] v [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = {4{32'hC0DE0000 + 32'(i)}};
      do_write(28'h40 + 28'(i), v[i], 16'hFFFF);
    end
    for (int i = 0; i < 4; i++) check_read("refill", 28'h40 + 28'(i), v[i]);
  endtask

  task automatic test_alias_ignore();
    do_write(28'h1005, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'hFFFF);
    check_read("alias", 28'h005, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    dvalid = 1'b1; dbits = '1; dmask = '1;
    tick();
    tick();
    idle_inputs();
    check_read("idle_dvalid", 28'h005, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
  endtask

  task automatic test_reset_mid_read();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h40;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_resp cyc=%0d got=%b exp=0", i, resp_valid); end
      tick();
    end
    check_read("rst_mid_next", 28'h5, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_alias_ignore();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
